sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 3, giving converter resolution in bits (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, the conversion request, sampled only in IDLE.
REQ-005 The block SHALL have port cmp, input, 1 bit, the comparator result: 1 = analog input >= level of current dac_code.
REQ-006 The block SHALL have port sample, output, 1 bit, the track/hold control: 1 = track input.
REQ-007 The block SHALL have port dac_code, output, N bits, the trial code driving the r_string_dac.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress (SAMPLE or CONVERT).
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when result is valid.
REQ-010 The block SHALL have port result, output, N bits, the last completed conversion code, held until overwritten.

Function
REQ-011 The FSM SHALL have states IDLE, SAMPLE, CONVERT and DONE, registered, with all outputs driven from registers.
REQ-012 IDLE: start=1 at an edge -> SAMPLE; start=0 -> stay in IDLE.
REQ-013 SAMPLE SHALL last exactly one cycle with sample=1 and dac_code=0, then go to CONVERT with dac_code = 1<<(N-1) and bit index = N-1.
REQ-014 CONVERT, each edge: if cmp=1, keep the bit under test, else clear it; if index > 0, set bit index-1 and decrement index; if index = 0, go to DONE.
REQ-015 CONVERT SHALL last exactly N cycles; cmp SHALL be sampled only in CONVERT and ignored otherwise.
REQ-016 On leaving CONVERT, result SHALL load the final code (the trial code after the last bit decision), and dac_code SHALL hold that code.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE (no back-to-back re-trigger).
REQ-018 Latency from the edge sampling start=1 to the done=1 cycle SHALL be N+2 edges; conversion throughput SHALL be one per N+3 cycles minimum.
REQ-019 busy SHALL be 1 in SAMPLE and CONVERT, and 0 in IDLE and DONE; sample SHALL be 1 only in SAMPLE.
REQ-020 start asserted during SAMPLE, CONVERT or DONE SHALL have no effect and SHALL not be queued.
REQ-021 The result code SHALL satisfy: DAC level(result) <= VIN < DAC level(result+1), with VIN = VSUP clamped to code 2^N-1, i.e. |VIN - level| <= VSUP/2^N.
REQ-022 In IDLE, dac_code SHALL hold its last value and result SHALL be stable.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE with dac_code=0, result=0, sample=0, busy=0, done=0 and index=N-1, taking priority over all other inputs.
REQ-024 rst asserted mid-conversion SHALL abort it with no done pulse, and result SHALL read 0.
REQ-025 After rst deasserts, start=1 at the first edge SHALL be honoured.

Verification (N=3, cmp modelled as vin_code >= dac_code, vin_code = floor(8*VIN/VSUP) clamped to 7)
REQ-026 VIN=0.7 V, VSUP=1.0 V, start pulse -> dac_code sequence 4,6,5; result=5; done at edge 5 after start.
REQ-027 VIN=1.0 V -> dac_code 4,6,7; result=7; VIN=0.0 V -> dac_code 4,2,1; result=0.
REQ-028 start held high continuously -> conversions repeat every 6 cycles, with one done pulse each and no extra conversions.
REQ-029 start pulsed during CONVERT -> ignored, and the conversion ends exactly once with unchanged timing.
REQ-030 rst at the second CONVERT cycle -> next cycle IDLE, all outputs 0, no done; a following start produces a correct result.
REQ-031 Random VIN in [0,1] over 1000 conversions -> result within one LSB (0.125 V) of VIN, and a property checker holds busy/done/sample mutually consistent with the FSM state.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
// The controller runs a one-cycle track phase, then N bit decisions (MSB first)
// against an external comparator, then a one-cycle done pulse.
// Every output comes straight from a flop, so the DAC and the track/hold switch
// see glitch-free control.
module sar_adc_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  // Width of the bit-under-test index; at least one bit so the N=1 case still elaborates.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [N-1:0]     LSB_ONE = N'(1);
  localparam logic [N-1:0]     MSB_ONE = LSB_ONE << (N - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N-1:0]     code_nxt;
  logic [N-1:0]     result_nxt;
  logic [N-1:0]     bit_mask;
  logic [N-1:0]     trial;

  // Next-state and next-code logic. The bit under test is chosen with a shifted
  // mask rather than a variable index, so the code stays width-clean for any N.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    code_nxt   = dac_code;
    result_nxt = result;
    bit_mask   = LSB_ONE << idx;
    trial      = cmp ? dac_code : (dac_code & ~bit_mask);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SAMPLE;
          code_nxt  = '0;
        end
      end
      SAMPLE: begin
        state_nxt = CONVERT;
        code_nxt  = MSB_ONE;
        idx_nxt   = IDX_TOP;
      end
      CONVERT: begin
        if (idx != '0) begin
          code_nxt = trial | (bit_mask >> 1);
          idx_nxt  = idx - IDX_W'(1);
        end else begin
          // Last decision: the DAC keeps showing the final code after conversion.
          code_nxt   = trial;
          result_nxt = trial;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here, which forces an IDLE cycle
        // between conversions.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; status outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= IDX_TOP;
      dac_code <= '0;
      result   <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      dac_code <= code_nxt;
      result   <= result_nxt;
      sample   <= (state_nxt == SAMPLE);
      busy     <= (state_nxt == SAMPLE) || (state_nxt == CONVERT);
      done     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl (N=3) with an ideal comparator model.
module tb_sar_adc_ctrl;

  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cmp;
  logic         sample;
  logic [N-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  logic [N-1:0] vin_code;
  logic         cmp_noise;
  logic         chk_en;
  logic         done_prev;
  int           vectors;
  int           miscompares;
  int           done_cnt;

  sar_adc_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmp      (cmp),
    .sample   (sample),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator while converting (busy and not tracking); random junk
  // otherwise, which the controller must ignore.
  always_comb cmp = (busy && !sample) ? (vin_code >= dac_code) : cmp_noise;

  always @(negedge clk) cmp_noise <= 1'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Status consistency: sample implies busy, done excludes busy/sample, and
  // done never lasts two cycles.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("prop_sample_busy", 32'(sample & ~busy), 32'd0);
      chk("prop_done_excl", 32'(done & (busy | sample)), 32'd0);
      chk("prop_done_1cyc", 32'(done & done_prev), 32'd0);
      if (done) done_cnt++;
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Code shown during decision k: the top k bits already decided, plus the trial bit.
  function automatic int exp_trial(input int v, input int k);
    return ((v >> (N - k)) << (N - k)) | (1 << (N - 1 - k));
  endfunction

  // One conversion launched from IDLE; optionally pulse start mid-conversion.
  task automatic run_conv(input int v, input bit poke);
    int d0;
    d0 = done_cnt;
    vin_code = N'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("smp_sample", 32'(sample), 32'd1);
    chk("smp_busy", 32'(busy), 32'd1);
    chk("smp_dac", 32'(dac_code), 32'd0);
    for (int k = 0; k < N; k++) begin
      tick();
      start = (poke && k == 0) ? 1'b1 : 1'b0;
      chk("cnv_dac", 32'(dac_code), 32'(exp_trial(v, k)));
      chk("cnv_busy", 32'({busy, sample, done}), 32'd4);
    end
    start = 1'b0;
    tick();
    chk("done_pulse", 32'({done, busy, sample}), 32'd4);
    chk("done_result", 32'(result), 32'(v));
    chk("done_dac", 32'(dac_code), 32'(v));
    tick();
    chk("idle_flags", 32'({done, busy, sample}), 32'd0);
    chk("idle_result", 32'(result), 32'(v));
    tick();
    chk("idle_noqueue", 32'({busy, dac_code}), 32'(v));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    real vin;
    real err;
    int  vc;
    int  d0;

    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    done_prev   = 1'b0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    vin_code    = '0;

    // Reset state, and reset wins over start.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_flags", 32'({sample, busy, done}), 32'd0);
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // VIN = 0.7, 1.0, 0.0 volts.
    run_conv(5, 1'b0);
    run_conv(7, 1'b0);
    run_conv(0, 1'b0);
    // start pulsed during CONVERT is ignored.
    run_conv(3, 1'b1);

    // start held high: one conversion every N+3 cycles.
    d0 = done_cnt;
    vin_code = 3'd2;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < N + 3; t++) begin
        tick();
        if (t == 0) chk("hold_sample", 32'({sample, busy}), 32'd3);
        else if (t <= N) chk("hold_dac", 32'(dac_code), 32'(exp_trial(2, t - 1)));
        else if (t == N + 1) chk("hold_done", 32'({done, result}), 32'h0a);
        else chk("hold_gap", 32'({done, busy}), 32'd0);
      end
    end
    start = 1'b0;
    tick();
    chk("hold_stop", 32'(busy), 32'd0);
    chk("hold_count", 32'(done_cnt - d0), 32'd3);

    // Reset during the second CONVERT cycle aborts with no done.
    d0 = done_cnt;
    vin_code = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", 32'({sample, busy, done}), 32'd0);
    chk("abort_dac", 32'(dac_code), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    // First edge after reset release takes start.
    run_conv(6, 1'b0);

    // Random input voltages.
    for (int i = 0; i < 1000; i++) begin
      vin = real'($urandom_range(0, 1000)) / 1000.0;
      vc = int'($floor(8.0 * vin));
      if (vc > 7) vc = 7;
      run_conv(vc, i[0]);
      err = vin - real'(result) * 0.125;
      if (err < 0.0) err = -err;
      chk("rand_lsb", 32'(err <= 0.125), 32'd1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
